// File: rtl/wb_fifo_slave_if.sv
// Wishbone classic bus bundle for wb_fifo_slave.
// The master modport drives requests; the slave modport answers them.
interface wb_fifo_slave_if;
  logic [31:0] s_wb_addr_i;
  logic [31:0] s_wb_data_i;
  logic [31:0] s_wb_data_o;
  logic        s_wb_we_i;
  logic        s_wb_cyc_i;
  logic        s_wb_stb_i;
  logic        s_wb_ack_o;
  logic        s_wb_err_o;

  modport master (
    output s_wb_addr_i, s_wb_data_i, s_wb_we_i,
    output s_wb_cyc_i, s_wb_stb_i,
    input  s_wb_data_o, s_wb_ack_o, s_wb_err_o
  );

  modport slave (
    input  s_wb_addr_i, s_wb_data_i, s_wb_we_i,
    input  s_wb_cyc_i, s_wb_stb_i,
    output s_wb_data_o, s_wb_ack_o, s_wb_err_o
  );
endinterface

// File: rtl/wb_fifo_slave.sv
// Wishbone slave with FIFO, status, control and scratch registers.
// Define WB_ERR_EN to end faulting cycles with err instead of ack.
module wb_fifo_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          DEPTH_LOG2 = 4,
  parameter int          ACK_DLY    = 0,
  parameter int          IRQ_LEVEL  = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  wb_fifo_slave_if.slave s_wb,
  output logic          irq_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                r_state, w_next;
  logic [3:0]            r_dly, w_dly_nxt;
  logic [31:2]           r_addr;
  logic [31:0]           r_wdat;
  logic                  r_we;
  logic [31:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wp, r_rp;
  logic [CW-1:0]         r_cnt;
  logic                  r_ovf, r_udf;
  logic [31:0]           r_scratch;

  logic        w_hit, w_empty, w_full, w_commit;
  logic        w_push, w_pop, w_push_ok, w_pop_ok;
  logic        w_ctrl, w_flush, w_clr;
  logic [1:0]  w_sel;
  logic [31:0] w_rdata;

  assign w_hit     = r_addr[31:4] == BASE_ADDR[31:4];
  assign w_sel     = r_addr[3:2];
  assign w_empty   = r_cnt == '0;
  assign w_full    = r_cnt == CW'(DEPTH);
  assign w_commit  = r_state == S_ACK;
  assign w_push    = w_commit & w_hit & r_we & (w_sel == 2'd0);
  assign w_pop     = w_commit & w_hit & ~r_we & (w_sel == 2'd0);
  assign w_push_ok = w_push & ~w_full;
  assign w_pop_ok  = w_pop & ~w_empty;
  assign w_ctrl    = w_commit & w_hit & r_we & (w_sel == 2'd2);
  assign w_flush   = w_ctrl & r_wdat[0];
  assign w_clr     = w_ctrl & r_wdat[1];

  always_comb begin
    w_rdata = '0;
    if (w_commit && w_hit && !r_we) begin
      case (w_sel)
        2'd0:    w_rdata = w_empty ? '0 : r_mem[r_rp];
        2'd1:    w_rdata = {8'b0, 8'(r_cnt), 12'b0,
                            r_udf, r_ovf, w_full, w_empty};
        2'd3:    w_rdata = r_scratch;
        default: w_rdata = '0;
      endcase
    end
  end

  assign s_wb.s_wb_data_o = w_rdata;

`ifdef WB_ERR_EN
  logic w_fault;
  assign w_fault = w_commit & (~w_hit | (w_push & w_full)
                               | (w_pop & w_empty));
  assign s_wb.s_wb_ack_o = w_commit & ~w_fault;
  assign s_wb.s_wb_err_o = w_fault;
`else
  assign s_wb.s_wb_ack_o = w_commit;
  assign s_wb.s_wb_err_o = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_dly_nxt = r_dly;
    case (r_state)
      S_IDLE:
        if (s_wb.s_wb_cyc_i && s_wb.s_wb_stb_i) begin
          if (ACK_DLY == 0) begin
            w_next = S_ACK;
          end else begin
            w_next    = S_WAIT;
            w_dly_nxt = 4'(ACK_DLY - 1);
          end
        end
      S_WAIT:
        if (!s_wb.s_wb_cyc_i)  w_next = S_IDLE;
        else if (r_dly == '0)  w_next = S_ACK;
        else                   w_dly_nxt = r_dly - 4'd1;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_dly   <= '0;
      r_addr  <= '0;
      r_wdat  <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dly   <= w_dly_nxt;
      if (r_state == S_IDLE && s_wb.s_wb_cyc_i && s_wb.s_wb_stb_i) begin
        r_addr <= s_wb.s_wb_addr_i[31:2];
        r_wdat <= s_wb.s_wb_data_i;
        r_we   <= s_wb.s_wb_we_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wp] <= r_wdat;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      r_scratch <= '0;
      irq_o     <= 1'b0;
    end else begin
      // flush only rewinds the pointers; stored words are left in place
      if (w_flush) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else if (w_push_ok) begin
        r_wp  <= r_wp + 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end else if (w_pop_ok) begin
        r_rp  <= r_rp + 1'b1;
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_clr)               r_ovf <= 1'b0;
      else if (w_push & w_full) r_ovf <= 1'b1;
      if (w_clr)                r_udf <= 1'b0;
      else if (w_pop & w_empty) r_udf <= 1'b1;
      if (w_commit && w_hit && r_we && w_sel == 2'd3)
        r_scratch <= r_wdat;
      irq_o <= (32'(r_cnt) >= 32'(IRQ_LEVEL)) | r_ovf;
    end
  end
endmodule

// File: tb/tb_wb_fifo_slave.sv
// Scoreboard bench for wb_fifo_slave: random and directed traffic
// checked against a queue-based model; one fast and one slow instance.
module tb_wb_fifo_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq0, irq1;

  always #5 clk = ~clk;

  wb_fifo_slave_if bus0();
  wb_fifo_slave_if bus1();

  wb_fifo_slave #(
    .BASE_ADDR(32'h0), .DEPTH_LOG2(4), .ACK_DLY(0), .IRQ_LEVEL(8)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .s_wb(bus0), .irq_o(irq0)
  );

  wb_fifo_slave #(
    .BASE_ADDR(32'h0), .DEPTH_LOG2(4), .ACK_DLY(5), .IRQ_LEVEL(8)
  ) u_dly (
    .clk_i(clk), .rst_i(rst), .s_wb(bus1), .irq_o(irq1)
  );

`ifdef WB_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  typedef struct {
    logic [31:0] d;
    bit          er;
  } exp_t;

  exp_t exp0[$];
  exp_t exp1[$];
  exp_t e0, e1;
  int   total = 0;
  int   bad   = 0;

  int          mq[$];
  bit          m_ovf, m_udf;
  logic [31:0] m_scr;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // reference: FIFO as a queue, registers as plain variables
  task automatic model(input logic [31:0] a, input bit we,
                       input logic [31:0] wd,
                       output logic [31:0] rd, output bit er);
    int n;
    n  = mq.size();
    rd = '0;
    er = 1'b0;
    if (a[31:4] != 28'h0) begin
      er = 1'b1;
    end else begin
      case (a[3:2])
        2'd0:
          if (we) begin
            if (n == 16) begin m_ovf = 1'b1; er = 1'b1; end
            else mq.push_back(int'(wd));
          end else begin
            if (n == 0) begin m_udf = 1'b1; er = 1'b1; end
            else rd = 32'(mq.pop_front());
          end
        2'd1:
          if (!we) rd = (32'(n) << 16) | {28'b0, m_udf, m_ovf,
                                          n == 16, n == 0};
        2'd2:
          if (we) begin
            if (wd[0]) mq.delete();
            if (wd[1]) begin m_ovf = 1'b0; m_udf = 1'b0; end
          end
        default:
          if (we) m_scr = wd;
          else    rd = m_scr;
      endcase
    end
    er = er & ERR;
  endtask

  task automatic drive(input bit s, input bit cs, input logic [31:0] a,
                       input bit we, input logic [31:0] wd);
    if (s) begin
      bus1.s_wb_addr_i = a;  bus1.s_wb_data_i = wd;
      bus1.s_wb_we_i   = we; bus1.s_wb_cyc_i  = cs;
      bus1.s_wb_stb_i  = cs;
    end else begin
      bus0.s_wb_addr_i = a;  bus0.s_wb_data_i = wd;
      bus0.s_wb_we_i   = we; bus0.s_wb_cyc_i  = cs;
      bus0.s_wb_stb_i  = cs;
    end
  endtask

  task automatic xact(input bit s, input logic [31:0] a, input bit we,
                      input logic [31:0] wd, input logic [31:0] ed,
                      input bit ee);
    exp_t e;
    int   n;
    bit   done;
    e.d  = ed;
    e.er = ee;
    @(negedge clk);
    if (s) exp1.push_back(e);
    else   exp0.push_back(e);
    drive(s, 1'b1, a, we, wd);
    n    = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      done = s ? (bus1.s_wb_ack_o | bus1.s_wb_err_o)
               : (bus0.s_wb_ack_o | bus0.s_wb_err_o);
    end
    chk(s ? "latency1" : "latency0", 32'(n), s ? 32'd6 : 32'd1);
    if (!done) begin
      if (s && exp1.size() > 0) void'(exp1.pop_back());
      if (!s && exp0.size() > 0) void'(exp0.pop_back());
    end
    drive(s, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
  endtask

  task automatic op0(input logic [31:0] a, input bit we,
                     input logic [31:0] wd);
    logic [31:0] ed;
    bit          ee;
    model(a, we, wd, ed, ee);
    xact(1'b0, a, we, wd, ed, ee);
    @(posedge clk);
    #1;
    chk("irq0", {31'b0, irq0},
        {31'b0, (mq.size() >= 8) | m_ovf});
  endtask

  always @(negedge clk) begin
    if (bus0.s_wb_ack_o | bus0.s_wb_err_o) begin
      if (exp0.size() == 0) begin
        total++; bad++;
        $display("FAIL mon0 stray ack=%b err=%b want=none",
                 bus0.s_wb_ack_o, bus0.s_wb_err_o);
      end else begin
        e0 = exp0.pop_front();
        chk("mon0 data", bus0.s_wb_data_o, e0.d);
        chk("mon0 err", {31'b0, bus0.s_wb_err_o}, {31'b0, e0.er});
        chk("mon0 ack", {31'b0, bus0.s_wb_ack_o}, {31'b0, !e0.er});
      end
    end else begin
      chk("mon0 idle data", bus0.s_wb_data_o, 32'h0);
    end
    if (bus1.s_wb_ack_o | bus1.s_wb_err_o) begin
      if (exp1.size() == 0) begin
        total++; bad++;
        $display("FAIL mon1 stray ack=%b err=%b want=none",
                 bus1.s_wb_ack_o, bus1.s_wb_err_o);
      end else begin
        e1 = exp1.pop_front();
        chk("mon1 data", bus1.s_wb_data_o, e1.d);
        chk("mon1 err", {31'b0, bus1.s_wb_err_o}, {31'b0, e1.er});
      end
    end
  end

  initial begin
    logic [31:0] a, wd;
    bit          we;
    int          r;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_scr = '0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("reset ack0", {31'b0, bus0.s_wb_ack_o}, 32'h0);
    chk("reset err0", {31'b0, bus0.s_wb_err_o}, 32'h0);
    chk("reset irq0", {31'b0, irq0}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    op0(32'h4, 1'b0, 32'h0);
    op0(32'h0, 1'b1, 32'hDEAD_BEEF);
    op0(32'h0, 1'b1, 32'h1234_5678);
    op0(32'h0, 1'b0, 32'h0);
    op0(32'h0, 1'b0, 32'h0);
    op0(32'h4, 1'b0, 32'h0);

    for (int i = 0; i < 17; i++) op0(32'h0, 1'b1, $urandom);
    op0(32'h4, 1'b0, 32'h0);
    op0(32'h8, 1'b1, 32'h3);
    op0(32'h4, 1'b0, 32'h0);

    op0(32'h0, 1'b0, 32'h0);
    op0(32'h4, 1'b0, 32'h0);
    op0(32'h8, 1'b1, 32'h2);

    op0(32'h20, 1'b1, 32'hFFFF_FFFF);
    op0(32'h2C, 1'b0, 32'h0);
    op0(32'h4, 1'b0, 32'h0);
    op0(32'hC, 1'b0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 9);
      wd = $urandom;
      we = ($urandom_range(0, 9) < 6);
      case (r)
        0, 1, 2, 3: a = 32'h0;
        4:          a = 32'h4;
        5: begin
          a  = 32'h8;
          we = ($urandom_range(0, 3) != 0);
          wd = 32'($urandom_range(0, 3));
        end
        6, 7:       a = 32'hC;
        default: begin
          a = $urandom;
          if (a[31:4] == 28'h0) a[4] = 1'b1;
        end
      endcase
      a[1:0] = 2'b00;
      op0(a, we, wd);
    end

    xact(1'b1, 32'hC, 1'b1, 32'hA5A5_0F0F, 32'h0, 1'b0);
    xact(1'b1, 32'hC, 1'b0, 32'h0, 32'hA5A5_0F0F, 1'b0);

    @(negedge clk);
    drive(1'b1, 1'b1, 32'hC, 1'b1, 32'h1111_1111);
    repeat (3) @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (12) @(posedge clk);
    xact(1'b1, 32'hC, 1'b0, 32'h0, 32'hA5A5_0F0F, 1'b0);

    @(negedge clk);
    drive(1'b1, 1'b1, 32'h0, 1'b1, 32'h7777_7777);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst ack1", {31'b0, bus1.s_wb_ack_o}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_scr = '0;
    repeat (10) @(posedge clk);
    xact(1'b1, 32'h4, 1'b0, 32'h0, 32'h0000_0001, 1'b0);
    op0(32'h4, 1'b0, 32'h0);
    op0(32'hC, 1'b0, 32'h0);

    repeat (3) @(posedge clk);
    chk("pending0", 32'(exp0.size()), 32'h0);
    chk("pending1", 32'(exp1.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
